// File: rtl/multi_counter_delayed_trigger.sv
// Multi-channel counter-delayed trigger: a shared reference counter, restarted by
// counter_reset edges, drives per-channel trigger pulses a programmable lead before period end.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for an arm rising edge while enabled
// ST_ARMED  | waiting for the counter to reach the channel target
// ST_FIRING | trigger high; pulse down-counter running (0 = latched)
// ST_DONE   | one-shot finished; only trigger_reset leaves this state
module multi_counter_delayed_trigger #(
    parameter int COUNTER_WIDTH = 32,
    parameter int CHANNELS      = 4,
    parameter int PULSE_BITS    = 8,
    parameter int FIRE_BITS     = 16
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              enable,
    input  logic                              counter_reset,
    input  logic [CHANNELS-1:0]               arm,
    input  logic [CHANNELS-1:0]               trigger_reset,
    input  logic [CHANNELS-1:0]               repeat_mode,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] presamples,
    input  logic [CHANNELS*PULSE_BITS-1:0]    pulse_len,
    input  logic [COUNTER_WIDTH-1:0]          reference_counter,
    output logic [CHANNELS-1:0]               trigger,
    output logic [CHANNELS-1:0]               armed_status,
    output logic [COUNTER_WIDTH-1:0]          last_counter,
    output logic [CHANNELS*FIRE_BITS-1:0]     fire_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FIRING = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PULSE_BITS-1:0]    PULSE_ONE = {{(PULSE_BITS-1){1'b0}}, 1'b1};
    localparam logic [FIRE_BITS-1:0]     FIRE_ONE  = {{(FIRE_BITS-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic [COUNTER_WIDTH-1:0] last_counter_q, last_counter_d;
    logic                     counter_reset_q;
    logic [CHANNELS-1:0]      arm_q;
    logic                     ref_edge;
    logic [CHANNELS-1:0]      arm_edge;

    state_e                   state_q     [CHANNELS];
    state_e                   state_d     [CHANNELS];
    logic [PULSE_BITS-1:0]    pulse_rem_q [CHANNELS];
    logic [PULSE_BITS-1:0]    pulse_rem_d [CHANNELS];
    logic [FIRE_BITS-1:0]     fire_cnt_q  [CHANNELS];
    logic [FIRE_BITS-1:0]     fire_cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]      trigger_q, trigger_d;

    logic [COUNTER_WIDTH-1:0] target [CHANNELS];
    logic [CHANNELS-1:0]      match;

    // Edge registers always track their inputs, so edges seen while disabled are consumed.
    assign ref_edge = counter_reset & ~counter_reset_q;
    assign arm_edge = arm & ~arm_q;

    always_comb begin
        counter_d      = counter_q;
        last_counter_d = last_counter_q;
        if (ref_edge) begin
            last_counter_d = counter_q;
            counter_d      = '0;
        end else if (enable) begin
            counter_d = counter_q + CNT_ONE;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target[i] = '0;
            if (presamples[i*COUNTER_WIDTH +: COUNTER_WIDTH] < reference_counter) begin
                target[i] = reference_counter - presamples[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
            match[i] = enable && !ref_edge && (counter_q == target[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]     = state_q[i];
            pulse_rem_d[i] = pulse_rem_q[i];
            fire_cnt_d[i]  = fire_cnt_q[i];
            trigger_d[i]   = trigger_q[i];

            case (state_q[i])
                ST_IDLE: begin
                    if (arm_edge[i] && enable) begin
                        state_d[i] = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (match[i]) begin
                        state_d[i]     = ST_FIRING;
                        trigger_d[i]   = 1'b1;
                        pulse_rem_d[i] = pulse_len[i*PULSE_BITS +: PULSE_BITS];
                        if (fire_cnt_q[i] != {FIRE_BITS{1'b1}}) begin
                            fire_cnt_d[i] = fire_cnt_q[i] + FIRE_ONE;
                        end
                    end
                end
                ST_FIRING: begin
                    // A zero remainder means the pulse was loaded as a latch.
                    if (pulse_rem_q[i] == PULSE_ONE) begin
                        pulse_rem_d[i] = '0;
                        trigger_d[i]   = 1'b0;
                        state_d[i]     = repeat_mode[i] ? ST_ARMED : ST_DONE;
                    end else if (pulse_rem_q[i] != '0) begin
                        pulse_rem_d[i] = pulse_rem_q[i] - PULSE_ONE;
                    end
                end
                ST_DONE: begin
                    trigger_d[i] = 1'b0;
                end
                default: begin
                    state_d[i]   = ST_IDLE;
                    trigger_d[i] = 1'b0;
                end
            endcase

            if (trigger_reset[i]) begin
                state_d[i]     = ST_IDLE;
                pulse_rem_d[i] = '0;
                fire_cnt_d[i]  = '0;
                trigger_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            counter_q       <= '0;
            last_counter_q  <= '0;
            counter_reset_q <= 1'b0;
            arm_q           <= '0;
            trigger_q       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]     <= ST_IDLE;
                pulse_rem_q[i] <= '0;
                fire_cnt_q[i]  <= '0;
            end
        end else begin
            counter_q       <= counter_d;
            last_counter_q  <= last_counter_d;
            counter_reset_q <= counter_reset;
            arm_q           <= arm;
            trigger_q       <= trigger_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]     <= state_d[i];
                pulse_rem_q[i] <= pulse_rem_d[i];
                fire_cnt_q[i]  <= fire_cnt_d[i];
            end
        end
    end

    always_comb begin
        armed_status = '0;
        fire_count   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            armed_status[i]                        = (state_q[i] == ST_ARMED);
            fire_count[i*FIRE_BITS +: FIRE_BITS] = fire_cnt_q[i];
        end
    end

    assign trigger      = trigger_q;
    assign last_counter = last_counter_q;

endmodule

// File: doc/multi_counter_delayed_trigger.md
# multi_counter_delayed_trigger

Multi-channel, parametrised successor to the single-channel counter-delayed trigger. A shared free-running reference counter is restarted by an external reference event (`counter_reset`). Each of `CHANNELS` independent channels fires a programmable-width trigger pulse `presamples` counts before the reference period ends. Channels run in one-shot or repeat mode. The block sits between the reference/clock-sync logic and the ADC/DAC sequencing blocks in the FPGA fabric.

## Interface
- `COUNTER_WIDTH`, 32, width of the reference counter, `presamples` and `reference_counter`
- `CHANNELS`, 4, number of independent trigger channels
- `PULSE_BITS`, 8, width of each per-channel pulse-length field
- `FIRE_BITS`, 16, width of each per-channel fire counter

Ports:
- `clk` in 1: sole clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `enable` in 1: global enable; gates counting, arming and firing.
- `counter_reset` in 1: reference event; rising edge restarts the counter.
- `arm` in CHANNELS: per-channel arm request; rising-edge sensitive.
- `trigger_reset` in CHANNELS: per-channel clear; level, synchronous.
- `repeat_mode` in CHANNELS: 0 = one-shot, 1 = re-arm after each pulse.
- `presamples` in CHANNELS*COUNTER_WIDTH: per-channel lead, packed with ch0 in the LSBs.
- `pulse_len` in CHANNELS*PULSE_BITS: per-channel pulse length in cycles; 0 = latch.
- `reference_counter` in COUNTER_WIDTH: shared reference period length.
- `trigger` out CHANNELS: registered trigger outputs.
- `armed_status` out CHANNELS: high while the channel is in ARMED.
- `last_counter` out COUNTER_WIDTH: counter value captured at the last reference event.
- `fire_count` out CHANNELS*FIRE_BITS: per-channel fire events since the last `trigger_reset`; saturating.

## Operation
- Reset: all outputs are 0, the counter is 0, every channel is IDLE, and the edge-detect registers are 0.
- Counter:
  - Increments by 1 each cycle while `enable`=1, wrapping modulo 2^COUNTER_WIDTH.
  - Holds its value while `enable`=0.
- Reference event: a rising edge of `counter_reset` (registered edge detect) restarts the counter.
  - Edges are detected regardless of `enable`.
  - On the edge cycle: `last_counter` <= counter, and counter <= 0.
- Target per channel:
  - If `presamples` < `reference_counter`: target = `reference_counter` − `presamples`.
  - Otherwise: target = 0.
  - The target is computed combinationally from the live inputs.
- Match for a channel: counter == target AND `enable`=1 AND no reference edge this cycle.
- Channel FSM, states IDLE, ARMED, FIRING, DONE:
  - IDLE -> ARMED: on an `arm` rising edge with `enable`=1. Edges seen while `enable`=0 are discarded.
  - ARMED -> FIRING: on match. `fire_count`++ (saturating at all-ones).
  - FIRING with `pulse_len`=N>0: `trigger` stays high for exactly N cycles, then:
    - `repeat_mode`=1 -> ARMED;
    - `repeat_mode`=0 -> DONE.
  - FIRING with `pulse_len`=0: `trigger` stays high until `trigger_reset`.
  - DONE: `trigger` is low; the channel ignores `arm` until `trigger_reset`.
  - `trigger_reset`=1, from any state: -> IDLE, `trigger` <= 0, `fire_count` <= 0. It has priority over arm and match in the same cycle.
- `enable`=0 effects:
  - No new arm or match occurs.
  - An ARMED channel stays ARMED.
  - An active FIRING pulse completes its count.
- Arming after the target has already passed in the current period: the channel fires in the next period.
- `pulse_len` is sampled at the ARMED->FIRING transition. Later changes do not affect the running pulse.
- Channels are fully independent apart from the shared counter, `enable` and `reference_counter`.

## Timing
- `arm` rising at input on cycle n (sampled at edge n) -> `armed_status` high from edge n+1.
- Match evaluated at edge k:
  - `trigger` high from edge k+1 to edge k+1+N, i.e. N cycles.
  - `armed_status` low from edge k+1.
  - `fire_count` updated at edge k+1.
- Repeat mode: `armed_status` high again on the edge that drops `trigger`.
  - A match on that same cycle is not taken, so the minimum re-fire spacing is one full period.
- `counter_reset` rising sampled at edge r: counter reads 0 and `last_counter` is valid after edge r.
- `trigger_reset` sampled at edge t: `trigger`, `armed_status` and `fire_count` are all 0 after edge t.
- `aresetn` low clears all state immediately, mid-pulse included. Operation resumes on the first edge after release.

## Test plan
- Basic one-shot:
  - Stimulus: ch0 with `reference_counter`=250, `presamples`=50, `pulse_len`=4, `repeat_mode`=0, arm, then a reference edge.
  - Required: `trigger[0]` high for 4 cycles starting 1 cycle after the counter hits 200; then DONE, `armed_status[0]`=0, `fire_count[0]`=1.
- Repeat mode:
  - Stimulus: ch1 with `repeat_mode`=1, `pulse_len`=2, `presamples`=10, three reference periods of 300 cycles each.
  - Required: 3 pulses, each starting 1 cycle after counter==240; `fire_count[1]`=3.
- Clamp and latch:
  - Stimulus: ch2 with `presamples`=300 > `reference_counter`=250, and `pulse_len`=0.
  - Required: fires at counter==0 after the next reference edge and stays high until `trigger_reset`.
- Enable and priority:
  - Stimulus 1: `enable`=0 with ch0 ARMED over the target.
  - Required 1: no trigger, counter frozen.
  - Stimulus 2: `trigger_reset` and `arm` in the same cycle.
  - Required 2: channel stays IDLE.
- Reference capture and reset:
  - Stimulus: reference edge at counter=1234.
  - Required: `last_counter`=1234 and counter=0 next cycle.
  - Stimulus: `aresetn` pulsed low mid-pulse.
  - Required: all outputs 0 asynchronously.
